// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes R-type ALU/M-extension requests, drives the ALU
// datapath select/control, launches multi-cycle mul/div units with a
// timeout watchdog and returns the captured result over a valid/ready port.
`timescale 1ns/1ps
module alu_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  output logic [2:0]       alu_select,
  output logic [1:0]       alu_control,
  output logic             mul_start,
  output logic             div_start,
  input  logic             mul_done,
  input  logic             div_done,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [1:0]       out_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  localparam logic [2:0] SEL_MUL = 3'b001;
  localparam logic [2:0] SEL_DIV = 3'b010;

  typedef enum logic [2:0] {IDLE, EXEC, MSTART, DSTART, WAIT, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic          dec_legal;
  logic [2:0]    dec_sel;
  logic [1:0]    dec_ctl;
  logic          accept;
  logic          unit_done;
  logic          timed_out;

  assign accept    = in_valid && in_ready;
  assign unit_done = (alu_select == SEL_MUL) ? mul_done : div_done;
  assign timed_out = (count == LAST);

  // Decode funct3/funct7 into unit select/control; unknown encodings are flagged illegal
  always_comb begin
    dec_legal = 1'b1;
    dec_sel   = 3'b000;
    dec_ctl   = 2'b00;
    case (funct7)
      7'b0000000: begin
        case (funct3)
          3'b000: dec_sel = 3'b000;
          3'b001: dec_sel = 3'b011;
          3'b010: dec_ctl = 2'b10;
          3'b011: dec_ctl = 2'b11;
          3'b100: dec_sel = 3'b101;
          3'b101: dec_sel = 3'b100;
          3'b110: dec_sel = 3'b110;
          3'b111: dec_sel = 3'b111;
          default: dec_legal = 1'b0;
        endcase
      end
      7'b0100000: begin
        case (funct3)
          3'b000: dec_ctl = 2'b01;
          3'b101: begin
            dec_sel = 3'b100;
            dec_ctl = 2'b01;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      7'b0000001: begin
        dec_sel = funct3[2] ? SEL_DIV : SEL_MUL;
        dec_ctl = funct3[1:0];
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake/launch outputs decoded from the current state
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    mul_start  = 1'b0;
    div_start  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (!dec_legal)             state_next = DONE;
          else if (dec_sel == SEL_MUL) state_next = MSTART;
          else if (dec_sel == SEL_DIV) state_next = DSTART;
          else                         state_next = EXEC;
        end
      end
      EXEC:   state_next = DONE;
      MSTART: begin
        mul_start  = 1'b1;
        state_next = WAIT;
      end
      DSTART: begin
        div_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (unit_done || timed_out) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers: decoded select, wait counter and the captured result/error
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_select  <= 3'b000;
      alu_control <= 2'b00;
      count       <= '0;
      out_result  <= '0;
      out_err     <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_select  <= dec_sel;
            alu_control <= dec_ctl;
            if (!dec_legal) begin
              out_result <= '0;
              out_err    <= 2'b01;
            end
          end
        end
        EXEC: begin
          out_result <= alu_result;
          out_err    <= 2'b00;
        end
        MSTART, DSTART: count <= '0;
        WAIT: begin
          count <= count + CW'(1);
          if (unit_done) begin
            out_result <= alu_result;
            out_err    <= 2'b00;
          end else if (timed_out) begin
            out_result <= '0;
            out_err    <= 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width.
REQ-002 Parameter TIMEOUT, default 64: maximum cycles to wait for a mul/div done before aborting.
REQ-003 clk  input  1: single clock, all state updates on rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 in_valid  input  1: request present.
REQ-006 in_ready  output  1: controller can accept a request.
REQ-007 funct3  input  3, funct7  input  7: R-type operation fields, sampled on accept.
REQ-008 alu_select  output  3, alu_control  output  2: registered unit select/control to the ALU datapath (encoding per REQ-016).
REQ-009 mul_start  output  1, div_start  output  1: single-cycle launch pulses to the multi-cycle units.
REQ-010 mul_done  input  1, div_done  input  1: unit completion strobes, one cycle wide.
REQ-011 alu_result  input  WIDTH: ALU datapath result (single-cycle paths and unit outputs muxed by alu_select).
REQ-012 out_valid  output  1, out_ready  input  1: result handshake.
REQ-013 out_result  output  WIDTH: captured result.
REQ-014 out_err  output  2: 00 ok, 01 illegal encoding, 10 unit timeout; qualified by out_valid.

Function
REQ-015 Request accepted when in_valid && in_ready; in_ready = 1 only in state IDLE.
REQ-016 Decode on accept: add 000/0000000 -> sel 000 ctl 00; sub 000/0100000 -> 000/01; slt 010/0000000 -> 000/10; sltu 011/0000000 -> 000/11; mul/mulh/mulhsu/mulhu funct3 000/001/010/011 with funct7 0000001 -> 001/00..11; div/divu/rem/remu funct3 100/101/110/111 with 0000001 -> 010/00..11; sll 001/0000000 -> 011/00; srl 101/0000000 -> 100/00; sra 101/0100000 -> 100/01; xor 100/0000000 -> 101/00; or 110/0000000 -> 110/00; and 111/0000000 -> 111/00.
REQ-017 Any other {funct3,funct7}: no unit launched, alu_select/alu_control = 000/00, out_result = 0, out_err = 01.
REQ-018 FSM states: IDLE, EXEC, MSTART, DSTART, WAIT, DONE.
REQ-019 IDLE: on accept go EXEC (select 000,011..111), MSTART (select 001), DSTART (select 010), or DONE with illegal error (REQ-017).
REQ-020 EXEC: alu_select/alu_control stable; capture alu_result into out_result at end of cycle; go DONE. Accept at cycle N -> out_valid at N+2.
REQ-021 MSTART/DSTART: assert mul_start/div_start for exactly one cycle; clear wait counter; go WAIT.
REQ-022 WAIT: counter increments each cycle; on the pending unit's done, capture alu_result, out_err = 00, go DONE; done of the non-pending unit is ignored.
REQ-023 WAIT: if counter reaches TIMEOUT-1 without done, go DONE with out_result = 0, out_err = 10; done arriving the same cycle as timeout wins (normal completion).
REQ-024 MSTART/DSTART: a done strobe in the start cycle is ignored.
REQ-025 DONE: out_valid = 1; out_result/out_err held stable until out_valid && out_ready; then go IDLE (in_ready next cycle, no same-cycle re-accept).
REQ-026 alu_select/alu_control hold the last decoded value from accept through DONE; only updated on accept.
REQ-027 Counter width $clog2(TIMEOUT)+1; no wrap possible before timeout exit.

Reset
REQ-028 rst in any state: next cycle state IDLE, in_ready = 1, out_valid = 0, mul_start = div_start = 0, out_result = 0, out_err = 00, alu_select = 000, alu_control = 00, counter = 0.
REQ-029 rst mid-WAIT abandons the operation; later done strobes in IDLE are ignored.

Verification
REQ-030 add (000/0000000) accepted cycle 0, alu_result = 5 -> alu_select 000/ctl 00 in cycle 1, out_valid cycle 2, out_result = 5, err 00.
REQ-031 mulhu (011/0000001) -> sel 001 ctl 11, mul_start one pulse cycle 1, mul_done cycle 6 with alu_result = 0xDEADBEEF -> out_valid cycle 7, out_result 0xDEADBEEF.
REQ-032 remu with div_done never asserted, TIMEOUT = 64 -> out_valid with out_err = 10, out_result = 0 exactly 64 cycles after WAIT entry.
REQ-033 funct3 = 001, funct7 = 0100000 -> no start pulse, out_valid cycle 1, out_err = 01, out_result = 0.
REQ-034 out_ready held low 10 cycles in DONE -> out_valid/out_result stable, in_ready 0; out_ready high -> in_ready 1 next cycle.
REQ-035 rst asserted during WAIT of div, div_done pulses 2 cycles later -> outputs at reset values, no out_valid.
